sequence_generator: RTL
=======================

// Module: sequence_generator
// PURPOSE
//  Serial pattern transmitter, the source side of the serial sequence-detector link.
//  Loads a PAT_W-bit pattern and a repeat count on a start request.
//  Shifts the pattern out MSB-first, one bit per clock, for the requested repetitions.
//  Feeds seq_in of a detector directly. Drives the stimulus stream for the detector family.
// PARAMETERS
//  PAT_W   3   pattern length in bits (>=1); default matches the 101 detector
//  CNT_W   4   width of repeat count; max repetitions = 2**CNT_W-1
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled only in IDLE
//  pattern   in   PAT_W  bits to send, bit [PAT_W-1] first; latched on accepted start
//  repeat_n  in   CNT_W  number of pattern repetitions; latched on accepted start
//  seq_out   out  1      serial data bit; connects to detector seq_in
//  seq_valid out  1      high while seq_out carries a pattern bit
//  busy      out  1      high in SHIFT and DONE; start ignored while high
//  done      out  1      one-cycle pulse after the last bit (or immediately if repeat_n=0)
// BEHAVIOUR
//  - All outputs are registered (Moore). Reset value: state=IDLE, seq_out=0, seq_valid=0,
//    busy=0, done=0, internal shift reg/counters=0.
//  - States: IDLE, SHIFT, DONE (2-bit encoding).
//    IDLE : start=1 & repeat_n!=0 -> SHIFT; latch pattern, rep_cnt=repeat_n, bit_cnt=PAT_W-1.
//           start=1 & repeat_n==0 -> DONE (no bits sent). start=0 -> IDLE.
//    SHIFT: each clock emits next bit. bit_cnt counts down to 0, then reloads to PAT_W-1,
//           and rep_cnt decrements. Leave when bit_cnt==0 & rep_cnt==1 -> DONE.
//    DONE : exactly one cycle; done=1, busy=1, seq_valid=0, seq_out=0; -> IDLE unconditionally.
//  - Latency: start accepted at edge k. First bit (pattern[PAT_W-1]) appears on seq_out with
//    seq_valid=1 after edge k. Then PAT_W*repeat_n consecutive valid cycles, with no gaps
//    between repetitions. done is high for the cycle after the last valid bit.
//  - Pattern is reused unchanged across repetitions. Changes on pattern/repeat_n after
//    acceptance have no effect until the next accepted start.
//  - start while busy (SHIFT or DONE) is ignored, not queued. Earliest restart is start
//    sampled in the IDLE cycle following DONE.
//  - seq_out=0 whenever seq_valid=0.
//  - Reset mid-operation: immediate async return to IDLE with reset values. No done pulse.
//    The partial stream is abandoned.
//  - Counters never wrap. rep_cnt width CNT_W; bit_cnt width $clog2(PAT_W) (min 1).
//  - Unreachable state encoding -> IDLE next cycle, outputs at reset values.
// TESTING
//  1 pattern=3'b101, repeat_n=1, start 1 cycle -> seq_out 1,0,1 with seq_valid=1 for 3 cycles;
//    done=1 on 4th cycle; busy high 4 cycles.
//  2 pattern=3'b101, repeat_n=2, looped into detector -> stream 101101 (6 valid cycles),
//    detector det_o high exactly twice (after bits 3 and 6).
//  3 repeat_n=0, start -> done=1 the cycle after start; seq_valid never high; back to IDLE.
//  4 start held high throughout repeat_n=1 run -> second transmission begins only in the
//    IDLE cycle after DONE (one idle cycle between streams); no start accepted in SHIFT/DONE.
//  5 change pattern to 3'b010 mid-stream of a 3'b110 run -> emitted bits stay 1,1,0.
//  6 assert reset on bit 2 of a repeat_n=3 run -> all outputs 0 asynchronously; no done pulse;
//    a fresh start afterwards sends a full, correct stream.

Source files
------------

// File: rtl/sequence_generator_if.sv
// Handshake bundle between a pattern source and the serial transmitter.
// The master drives the request side; the slave (transmitter) drives the serial stream.
interface sequence_generator_if #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 4
) ();
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n,
    input  seq_out, seq_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n,
    output seq_out, seq_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first,
// repeat_n times back to back, then pulses done for one cycle. All outputs registered.
module sequence_generator #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 4
) (
  input logic                 clock,
  input logic                 reset,
  sequence_generator_if.slave bus
);
  localparam int unsigned BitW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             seq_out_q, seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed one cycle ahead so they appear registered with the state.
  always_comb begin
    state_d     = StIdle;
    pat_d       = pat_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.repeat_n != '0) begin
            state_d     = StShift;
            pat_d       = bus.pattern;
            sh_d        = bus.pattern;
            bit_cnt_d   = BitLast;
            rep_cnt_d   = bus.repeat_n;
            seq_out_d   = bus.pattern[PAT_W-1];
            seq_valid_d = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StShift: begin
        busy_d = 1'b1;
        if (bit_cnt_q == '0) begin
          if (rep_cnt_q == CNT_W'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            // Next repetition starts immediately from the latched copy.
            state_d     = StShift;
            rep_cnt_d   = rep_cnt_q - CNT_W'(1);
            bit_cnt_d   = BitLast;
            sh_d        = pat_q;
            seq_out_d   = pat_q[PAT_W-1];
            seq_valid_d = 1'b1;
          end
        end else begin
          state_d     = StShift;
          bit_cnt_d   = bit_cnt_q - BitW'(1);
          sh_d        = sh_q << 1;
          seq_out_d   = sh_d[PAT_W-1];
          seq_valid_d = 1'b1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.seq_out   = seq_out_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
